// File: rtl/sa_output_drain.sv
// sa_output_drain: reads rows from the output memory and streams them on a valid/ready port.
// A 2-entry FIFO absorbs the one-cycle read latency and downstream back-pressure.
module sa_output_drain #(
  parameter  int NUM_ENTRIES = 8,
  parameter  int DATA_WIDTH  = 128,
  localparam int AW          = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [AW-1:0]         i_base_addr,
  input  logic [AW:0]           i_num_rows,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_cenb,
  output logic                  o_mem_wenb,
  output logic [AW-1:0]         o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  localparam logic [AW:0]   ONE       = (AW+1)'(1);
  localparam logic [AW:0]   MAX_ROWS  = (AW+1)'(NUM_ENTRIES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_ENTRIES - 1);

  state_e                state_q;
  logic [AW-1:0]         addr_q;
  logic [AW:0]           num_q;
  logic [AW:0]           issue_q;
  logic [AW:0]           beat_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  logic                  hs;
  logic                  issue;
  logic [AW:0]           num_clamped;
  logic [2:0]            pending;

  assign num_clamped = (i_num_rows > MAX_ROWS) ? MAX_ROWS : i_num_rows;
  assign o_valid     = (count_q != 2'd0);
  assign hs          = o_valid & i_ready;

  // Credit: rows buffered plus the read in flight, minus the row leaving now, must leave room.
  assign pending = {1'b0, count_q} + {2'b00, inflight_q};
  assign issue   = (state_q == READ) && (issue_q < num_q) &&
                   (pending <= (3'd1 + {2'b00, hs}));

  assign o_mem_cenb = ~issue;
  assign o_mem_wenb = 1'b1;
  assign o_mem_addr = addr_q;
  assign o_data     = fifo_q[rd_ptr_q];
  assign o_last     = o_valid && (beat_q == (num_q - ONE));
  assign o_busy     = busy_q;
  assign o_done     = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      num_q   <= '0;
      issue_q <= '0;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (hs) begin
        beat_q <= beat_q + ONE;
      end
      if (issue) begin
        issue_q <= issue_q + ONE;
        addr_q  <= (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
      end
      case (state_q)
        IDLE: begin
          if (i_start) begin
            addr_q  <= i_base_addr;
            num_q   <= num_clamped;
            issue_q <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            if (num_clamped == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (issue && ((issue_q + ONE) == num_q)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs && ((beat_q + ONE) == num_q)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data lands one cycle after the issue; the credit rule keeps occupancy at or below two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= i_mem_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (hs) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, hs};
    end
  end

endmodule
